fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared pipeline types and constants for the fetch queue
package fetch_queue_pkg;

   // Widest PC any pipeline configuration uses; narrower PCs are zero-extended into entries.
   localparam int PC_MAX_W = 64;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [PC_MAX_W-1:0] pc;
      logic [31:0]         instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue with registered ready/valid
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int N     = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N-1:0]               pc_F,
   input  logic [31:0]                instr_F,
   input  logic                       valid_F,
   output logic                       ready_F,
   input  logic                       flush,
   output logic [N-1:0]               pc_D,
   output logic [31:0]                instr_D,
   output logic                       valid_D,
   input  logic                       ready_D,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fq_entry_t         mem [DEPTH];
   fq_entry_t         wr_entry;
   fq_entry_t         head_entry;
   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic [CW-1:0]     count_q;
   logic              enq;
   logic              deq;

   // Handshakes decode from count_q only, so neither side sees the other combinationally.
   assign ready_F = (count_q != CW'(DEPTH));
   assign valid_D = (count_q != '0);
   assign count   = count_q;

   assign enq = valid_F && ready_F && !flush;
   assign deq = valid_D && ready_D && !flush;

   always_comb begin
      wr_entry       = '0;
      wr_entry.pc    = PC_MAX_W'(pc_F);
      wr_entry.instr = instr_F;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (enq) tail <= tail + AW'(1);
         if (deq) head <= head + AW'(1);
         case ({enq, deq})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; stale contents are hidden by the valid_D mask below.
   always_ff @(posedge clk) begin
      if (enq && !reset) mem[tail] <= wr_entry;
   end

   assign head_entry = mem[head];
   assign pc_D       = valid_D ? head_entry.pc[N-1:0] : '0;
   assign instr_D    = valid_D ? head_entry.instr : NOP;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - vector table, directed sequences and random model check of fetch_queue
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int N     = 64;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP_W = 32'h00000013;

   logic          clk = 1'b0;
   logic          reset, valid_F, flush, ready_D;
   logic [N-1:0]  pc_F;
   logic [31:0]   instr_F;
   logic          ready_F, valid_D;
   logic [N-1:0]  pc_D;
   logic [31:0]   instr_D;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc_F(pc_F), .instr_F(instr_F), .valid_F(valid_F),
      .ready_F(ready_F), .flush(flush), .pc_D(pc_D), .instr_D(instr_D),
      .valid_D(valid_D), .ready_D(ready_D), .count(count)
   );

   function automatic logic [31:0] instr_of(logic [63:0] pc);
      return pc[31:0] ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic vf, input logic [63:0] pc,
                       input logic fl, input logic rd);
      @(negedge clk);
      reset   = r;
      valid_F = vf;
      pc_F    = pc;
      instr_F = instr_of(pc);
      flush   = fl;
      ready_D = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input int exp_cnt, input logic [63:0] exp_pc);
      logic exp_vd;
      exp_vd = (exp_cnt != 0);
      check({tag, ".count"},   64'(count),   64'(exp_cnt));
      check({tag, ".valid_D"}, 64'(valid_D), 64'(exp_vd));
      check({tag, ".ready_F"}, 64'(ready_F), 64'(exp_cnt != DEPTH));
      check({tag, ".pc_D"},    pc_D,         exp_vd ? exp_pc : 64'h0);
      check({tag, ".instr_D"}, 64'(instr_D), 64'(exp_vd ? instr_of(exp_pc) : NOP_W));
   endtask

   typedef struct {
      logic        r;
      logic        vf;
      logic [63:0] pc;
      logic        fl;
      logic        rd;
      int          exp_cnt;
      logic [63:0] exp_pc;
   } vec_t;

   vec_t vecs[$];
   logic [63:0] model[$];

   initial begin
      reset = 1'b1; valid_F = 1'b0; pc_F = '0; instr_F = '0; flush = 1'b0; ready_D = 1'b0;

      //          r     vf    pc          fl    rd    cnt pc_D
      vecs.push_back('{1'b1, 1'b0, 64'h0,     1'b0, 1'b0, 0, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h0,     1'b0, 1'b0, 1, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h4,     1'b0, 1'b0, 2, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h8,     1'b0, 1'b0, 3, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'hC,     1'b0, 1'b0, 4, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h10,    1'b0, 1'b0, 4, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h14,    1'b0, 1'b1, 3, 64'h4});
      vecs.push_back('{1'b0, 1'b1, 64'h18,    1'b1, 1'b1, 0, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h200,   1'b0, 1'b0, 1, 64'h200});
      vecs.push_back('{1'b0, 1'b1, 64'h204,   1'b0, 1'b0, 2, 64'h200});
      vecs.push_back('{1'b1, 1'b1, 64'h208,   1'b0, 1'b1, 0, 64'h0});
      vecs.push_back('{1'b0, 1'b0, 64'h0,     1'b0, 1'b1, 0, 64'h0});
      vecs.push_back('{1'b0, 1'b1, 64'h300,   1'b0, 1'b1, 1, 64'h300});
      vecs.push_back('{1'b0, 1'b1, 64'h304,   1'b0, 1'b1, 1, 64'h304});
      vecs.push_back('{1'b1, 1'b1, 64'h308,   1'b1, 1'b1, 0, 64'h0});

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].vf, vecs[i].pc, vecs[i].fl, vecs[i].rd);
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_pc);
      end

      // Streaming: one entry in flight, a new head every cycle after the first.
      step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 64'h100 + 64'(4 * k), 1'b0, 1'b1);
         check_outputs($sformatf("stream%0d", k), 1, 64'h100 + 64'(4 * k));
      end

      // Full queue: ready_F must not react to ready_D within the cycle.
      step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 64'h40 + 64'(4 * k), 1'b0, 1'b0);
      @(negedge clk);
      valid_F = 1'b0;
      ready_D = 1'b1;
      #1;
      check("full.ready_F_comb", 64'(ready_F), 64'h0);
      @(posedge clk);
      #1;
      check_outputs("full_pop", DEPTH - 1, 64'h44);

      // Randomised run against a queue model; stalls and wraps arise naturally.
      step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      model.delete();
      for (int c = 0; c < 600; c++) begin
         logic r, vf, fl, rd, m_enq, m_deq;
         logic [63:0] pc;
         r  = ($urandom_range(0, 99) < 2);
         fl = ($urandom_range(0, 99) < 4);
         vf = ($urandom_range(0, 99) < 60);
         rd = ($urandom_range(0, 99) < 50);
         pc = 64'h1000 + 64'(4 * c);
         m_enq = vf && (model.size() < DEPTH) && !fl;
         m_deq = rd && (model.size() != 0) && !fl;
         step(r, vf, pc, fl, rd);
         if (r || fl) begin
            model.delete();
         end else begin
            if (m_deq) void'(model.pop_front());
            if (m_enq) model.push_back(pc);
         end
         check_outputs($sformatf("rand%0d", c), model.size(),
                       (model.size() != 0) ? model[0] : 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
